hslp_acc: RTL and testbench
===========================

HSLP_ACC -- requirements
Module: hslp_acc

Interface
REQ-001 Parameter: ACC_W, default 24, accumulator and sum width in bits (legal range 17..32).
REQ-002 Parameter: CNT_W, default 8, beat-counter width in bits.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  upstream product beat valid.
REQ-006 Port: in_ready  output  1  block can accept a beat this cycle.
REQ-007 Port: in_prod  input  16  unsigned 16-bit product from the 8x8 approximate multiplier (prod8).
REQ-008 Port: in_last  input  1  marks the final beat of a frame; qualified by in_valid.
REQ-009 Port: out_valid  output  1  frame sum available.
REQ-010 Port: out_ready  input  1  downstream accepts the frame sum.
REQ-011 Port: out_sum  output  ACC_W  accumulated frame sum.
REQ-012 Port: out_cnt  output  CNT_W  number of beats in the frame.
REQ-013 Port: out_ovf  output  1  sticky: some addition in the frame exceeded ACC_W bits.

Function
REQ-014 A beat is accepted exactly when in_valid and in_ready are both 1 on a rising edge.
REQ-015 The FSM has three states: IDLE (no beat accepted in the current frame), ACC (frame in progress) and HOLD (result pending).
REQ-016 in_ready shall be 1 in IDLE and ACC, and 0 in HOLD; in_ready is a pure function of state, with no combinational path from out_ready.
REQ-017 When a non-last beat is accepted: acc <= acc + zero-extended in_prod; cnt <= cnt + 1, saturating at all-ones; next state is ACC.
REQ-018 When a last beat is accepted, in IDLE or ACC: out_sum <= acc + in_prod; out_cnt <= cnt + 1, saturating; next state is HOLD, and out_valid = 1 from the following cycle.
REQ-019 A single-beat frame (in_last on the first beat, accepted in IDLE) yields out_sum = in_prod and out_cnt = 1, after 1 cycle of latency.
REQ-020 Latency is fixed: out_valid rises exactly 1 cycle after the last beat is accepted.
REQ-021 In HOLD, out_sum, out_cnt and out_ovf shall stay stable until out_valid and out_ready are both 1.
REQ-022 On an output handshake: out_valid <= 0; acc, cnt and the overflow flag clear to 0; next state is IDLE; a new beat can be accepted in the next cycle.
REQ-023 Overflow: out_ovf is set if any carry out of bit ACC_W-1 occurs in the frame, including the last-beat addition, and is cleared only by REQ-022 or by reset.
REQ-024 Without the saturation feature (REQ-028), the sum wraps modulo 2^ACC_W.
REQ-025 out_valid is 0 outside HOLD; out_valid asserted with out_ready = 0 holds indefinitely.

Reset
REQ-026 While rst_n = 0, the following hold immediately and asynchronously: state = IDLE; acc, cnt, out_sum, out_cnt = 0; out_valid, out_ovf = 0.
REQ-027 Reset asserted mid-frame or in HOLD discards the partial or pending result; the first beat after release starts a fresh frame.

Configuration
REQ-028 Macro HSLP_ACC_SAT_EN, when defined: every addition saturates at 2^ACC_W - 1 instead of wrapping; out_ovf still reports the saturation event.
REQ-029 Macro HSLP_ACC_SAT_EN, when undefined: additions wrap per REQ-024; no saturation logic is compiled in.

Structure
REQ-030 Shared package hslp_pkg holds: PROD_W = 16; the state enumeration {IDLE, ACC, HOLD}; the default ACC_W and CNT_W values.
REQ-031 One sub-module, hslp_acc_add: a combinational ACC_W-bit adder (acc + zero-extended product) producing the sum and a carry/ovf flag, with saturation selected by HSLP_ACC_SAT_EN; it is instantiated once.

Verification
REQ-032 Frame of 3 beats: 100, 200, 300 (last) -> out_valid exactly 1 cycle later with out_sum = 600, out_cnt = 3, out_ovf = 0.
REQ-033 Single beat 65025 (255*255) with in_last = 1 -> out_sum = 65025, out_cnt = 1.
REQ-034 Backpressure: out_ready held at 0 for 5 cycles -> in_ready = 0 throughout, outputs stable, in_valid beats not consumed; out_ready = 1 -> handshake, in_ready = 1 in the next cycle.
REQ-035 ACC_W = 17, 3 beats of 65535 -> wrap build: out_sum = 196605 mod 131072 = 65533, out_ovf = 1; SAT_EN build: out_sum = 131071, out_ovf = 1.
REQ-036 rst_n pulsed low after 2 beats of a frame -> outputs zero immediately; next frame 7, 8 (last) -> out_sum = 15, out_cnt = 2.
REQ-037 CNT_W = 2, frame of 5 beats of 1 -> out_cnt = 3 (saturated), out_sum = 5.

Source files
------------

// File: rtl/hslp_pkg.sv
// Shared constants and FSM state type for the product accumulator.
// The optional saturation build is selected with HSLP_ACC_SAT_EN.
package hslp_pkg;
   localparam int PROD_W    = 16;
   localparam int ACC_W_DEF = 24;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      HOLD
   } state_t;
endpackage

// File: rtl/hslp_acc_if.sv
// Product-beat input and frame-sum output handshake bundle.
// master drives beats and consumes sums; slave is the accumulator.
interface hslp_acc_if
   import hslp_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) ();
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_cnt;
   logic              out_ovf;

   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_cnt, out_ovf
   );

   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_cnt, out_ovf
   );
endinterface

// File: rtl/hslp_acc_add.sv
// Combinational accumulator adder with carry-out flag.
// HSLP_ACC_SAT_EN clamps the sum at all-ones instead of wrapping.
module hslp_acc_add
   import hslp_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  a,
   input  logic [PROD_W-1:0] b,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);
   logic [ACC_W:0] raw;

   assign raw = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
   assign ovf = raw[ACC_W];

`ifdef HSLP_ACC_SAT_EN
   assign sum = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
   assign sum = raw[ACC_W-1:0];
`endif
endmodule

// File: rtl/hslp_acc.sv
// Frame accumulator for approximate-multiplier products (IDLE/ACC/HOLD).
// Build option HSLP_ACC_SAT_EN selects saturating additions.
module hslp_acc
   import hslp_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic    clk,
   input  logic    rst_n,
   hslp_acc_if.slave bus
);
   state_t           state;
   state_t           nxt;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic [ACC_W-1:0] sum;
   logic             carry;
   logic [CNT_W-1:0] cnt_inc;
   logic             take;
   logic             give;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_cnt;
   logic             out_ovf;

   hslp_acc_add #(.ACC_W(ACC_W)) u_add (
      .a   (acc),
      .b   (bus.in_prod),
      .sum (sum),
      .ovf (carry)
   );

   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

   assign bus.in_ready  = (state != HOLD);
   assign bus.out_valid = (state == HOLD);
   assign bus.out_sum   = out_sum;
   assign bus.out_cnt   = out_cnt;
   assign bus.out_ovf   = out_ovf;

   assign take = bus.in_valid && bus.in_ready;
   assign give = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, ACC: begin
            if (take) nxt = bus.in_last ? HOLD : ACC;
         end
         HOLD: begin
            if (bus.out_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Result registers are written only on the last beat, so HOLD keeps them stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         out_sum <= '0;
         out_cnt <= '0;
         out_ovf <= 1'b0;
      end else begin
         unique case (1'b1)
            take && !bus.in_last: begin
               acc <= sum;
               cnt <= cnt_inc;
               ovf <= ovf | carry;
            end
            take && bus.in_last: begin
               out_sum <= sum;
               out_cnt <= cnt_inc;
               out_ovf <= ovf | carry;
            end
            give: begin
               acc     <= '0;
               cnt     <= '0;
               ovf     <= 1'b0;
               out_ovf <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_hslp_acc.sv
// Directed-vector bench for hslp_acc: default, ACC_W=17 and CNT_W=2 builds.
// All three instances share one stimulus stream.
module tb_hslp_acc;
   import hslp_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic [PROD_W-1:0] in_prod;
   logic              in_last;
   logic              out_ready;

   int nvec;
   int nerr;

   hslp_acc_if                     d0 ();
   hslp_acc_if #(.ACC_W(17))       d1 ();
   hslp_acc_if #(.CNT_W(2))        d2 ();

   assign d0.in_valid  = in_valid;
   assign d0.in_prod   = in_prod;
   assign d0.in_last   = in_last;
   assign d0.out_ready = out_ready;
   assign d1.in_valid  = in_valid;
   assign d1.in_prod   = in_prod;
   assign d1.in_last   = in_last;
   assign d1.out_ready = out_ready;
   assign d2.in_valid  = in_valid;
   assign d2.in_prod   = in_prod;
   assign d2.in_last   = in_last;
   assign d2.out_ready = out_ready;

   hslp_acc u_d0 (.clk(clk), .rst_n(rst_n), .bus(d0));
   hslp_acc #(.ACC_W(17)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(d1));
   hslp_acc #(.CNT_W(2))  u_d2 (.clk(clk), .rst_n(rst_n), .bus(d2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic beat(input logic [15:0] p, input logic last);
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = last;
      if (last) chk("pre_last_valid", 32'(d0.out_valid), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_prod  = '0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("pop_valid", 32'(d0.out_valid), 0);
      chk("pop_ready", 32'(d0.in_ready), 1);
   endtask

   initial begin
      nvec      = 0;
      nerr      = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_prod   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #2;
      chk("rst_valid", 32'(d0.out_valid), 0);
      chk("rst_sum",   32'(d0.out_sum), 0);
      chk("rst_cnt",   32'(d0.out_cnt), 0);
      chk("rst_ovf",   32'(d0.out_ovf), 0);
      chk("rst_ready", 32'(d0.in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // three-beat frame
      beat(16'd100, 1'b0);
      beat(16'd200, 1'b0);
      beat(16'd300, 1'b1);
      chk("f3_valid", 32'(d0.out_valid), 1);
      chk("f3_sum",   32'(d0.out_sum), 600);
      chk("f3_cnt",   32'(d0.out_cnt), 3);
      chk("f3_ovf",   32'(d0.out_ovf), 0);
      pop();

      // single-beat frame
      beat(16'd65025, 1'b1);
      chk("f1_valid", 32'(d0.out_valid), 1);
      chk("f1_sum",   32'(d0.out_sum), 65025);
      chk("f1_cnt",   32'(d0.out_cnt), 1);
      pop();

      // backpressure with a pending beat offered
      beat(16'd5, 1'b1);
      in_valid = 1'b1;
      in_prod  = 16'd99;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_ready", 32'(d0.in_ready), 0);
         chk("bp_valid", 32'(d0.out_valid), 1);
         chk("bp_sum",   32'(d0.out_sum), 5);
         chk("bp_cnt",   32'(d0.out_cnt), 1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_prod  = '0;
      pop();
      beat(16'd1, 1'b1);
      chk("bp_next_sum", 32'(d0.out_sum), 1);
      chk("bp_next_cnt", 32'(d0.out_cnt), 1);
      pop();

      // overflow at ACC_W = 17; default width holds it exactly
      beat(16'd65535, 1'b0);
      beat(16'd65535, 1'b0);
      beat(16'd65535, 1'b1);
`ifdef HSLP_ACC_SAT_EN
      chk("w17_sum", 32'(d1.out_sum), 131071);
`else
      chk("w17_sum", 32'(d1.out_sum), 65533);
`endif
      chk("w17_ovf", 32'(d1.out_ovf), 1);
      chk("w24_sum", 32'(d0.out_sum), 196605);
      chk("w24_ovf", 32'(d0.out_ovf), 0);
      pop();
      chk("w17_ovf_clr", 32'(d1.out_ovf), 0);

      // reset mid-frame
      beat(16'd10, 1'b0);
      beat(16'd20, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_sum",   32'(d0.out_sum), 0);
      chk("mr_cnt",   32'(d0.out_cnt), 0);
      chk("mr_valid", 32'(d0.out_valid), 0);
      chk("mr_ready", 32'(d0.in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      beat(16'd7, 1'b0);
      beat(16'd8, 1'b1);
      chk("mr_f_sum", 32'(d0.out_sum), 15);
      chk("mr_f_cnt", 32'(d0.out_cnt), 2);
      pop();

      // beat counter saturation at CNT_W = 2
      for (int i = 0; i < 4; i++) beat(16'd1, 1'b0);
      beat(16'd1, 1'b1);
      chk("c2_cnt", 32'(d2.out_cnt), 3);
      chk("c2_sum", 32'(d2.out_sum), 5);
      chk("c8_cnt", 32'(d0.out_cnt), 5);
      pop();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
